// File: rtl/comma_align_ctrl_pkg.sv
// Shared 1000BASE-X PCS definitions: comma patterns, K28.5 code groups
// and the word-alignment state encoding.
package comma_align_ctrl_pkg;

    localparam logic [6:0] COMMA_P     = 7'b0011111;
    localparam logic [6:0] COMMA_N     = 7'b1100000;
    localparam logic [9:0] K28_5_RDN   = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP   = 10'b1100000101;
    localparam int         NUM_OFFSETS = 10;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    // Only the leading seven bits of a code group carry the comma.
    function automatic logic is_comma(input logic [6:0] head);
        return (head == COMMA_P) || (head == COMMA_N);
    endfunction

endpackage

// File: rtl/comma_align_ctrl_comma_detect.sv
// Comma search over the 20-bit two-word window; hit[k] flags a comma
// starting at bit offset k.
module comma_detect
    import comma_align_ctrl_pkg::*;
(
    input  logic [19:0] window,
    output logic [9:0]  hit
);

    // The last four bits of the later word never fall in a comma head.
    logic [3:0] unused_tail;
    assign unused_tail = window[3:0];

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_OFFSETS; k++) begin
            hit[k] = is_comma(window[19-k -: 7]);
        end
    end

endmodule

// File: rtl/comma_align_ctrl.sv
// Receive word aligner: finds the comma offset in the raw deserializer
// stream, confirms it, and re-hunts when the synchronizer fails or drops.
//
// state   | meaning
// HUNT    | searching all offsets, lowest hit wins
// CONFIRM | counting further commas at the chosen offset
// LOCKED  | offset fixed, waiting for / watching sync_status
module comma_align_ctrl
    import comma_align_ctrl_pkg::*;
#(
    parameter int CONFIRM_COMMAS = 3,
    parameter int SYNC_TIMEOUT   = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [9:0]       rx_raw,
    input  logic             sync_status,
    output logic [9:0]       rx_code_group,
    output logic [3:0]       bit_offset,
    output logic             align_locked,
    output logic [CNT_W-1:0] realign_count
);

    localparam int CONF_W = (CONFIRM_COMMAS > 1) ? $clog2(CONFIRM_COMMAS) : 1;
    localparam int TMO_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CONF_W-1:0] CONF_LOAD = CONF_W'(CONFIRM_COMMAS - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(SYNC_TIMEOUT - 1);

    align_state_t      state;
    logic [9:0]        r0;
    logic [9:0]        r1;
    logic [19:0]       window;
    logic [9:0]        hit;
    logic [9:0]        own_mask;
    logic              own_hit;
    logic              other_hit;
    logic [3:0]        first_hit;
    logic [9:0]        cand_sel;
    logic [CONF_W-1:0] conf_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              sync_seen;
    logic              lose_lock;
    logic              unused_lsb;

    assign window = {r1, r0};
    // Offset 9 takes nine bits of the later word, so its last bit is never used.
    assign unused_lsb = window[0];

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r0 <= '0;
            r1 <= '0;
        end else begin
            r0 <= rx_raw;
            r1 <= r0;
        end
    end

    comma_detect u_comma_detect (
        .window (window),
        .hit    (hit)
    );

    assign own_mask  = 10'b1 << bit_offset;
    assign own_hit   = |(hit & own_mask);
    assign other_hit = |(hit & ~own_mask);

    always_comb begin
        first_hit = '0;
        for (int k = NUM_OFFSETS - 1; k >= 0; k--) begin
            if (hit[k]) first_hit = 4'(k);
        end
    end

    always_comb begin
        cand_sel = '0;
        for (int k = 0; k < NUM_OFFSETS; k++) begin
            if (bit_offset == 4'(k)) cand_sel = window[19-k -: 10];
        end
    end

    // A fall after sync was seen and an expired timeout are one event.
    assign lose_lock = sync_seen ? ~sync_status
                                 : (~sync_status & (tmo_cnt == '0));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state         <= HUNT;
            rx_code_group <= '0;
            bit_offset    <= '0;
            align_locked  <= 1'b0;
            realign_count <= '0;
            conf_cnt      <= '0;
            tmo_cnt       <= '0;
            sync_seen     <= 1'b0;
        end else begin
            rx_code_group <= cand_sel;
            case (state)
                HUNT: begin
                    if (|hit) begin
                        bit_offset <= first_hit;
                        conf_cnt   <= CONF_LOAD;
                        state      <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (other_hit) begin
                        state <= HUNT;
                    end else if (own_hit) begin
                        if (conf_cnt == '0) begin
                            state        <= LOCKED;
                            align_locked <= 1'b1;
                            tmo_cnt      <= TMO_LOAD;
                            sync_seen    <= 1'b0;
                        end else begin
                            conf_cnt <= conf_cnt - CONF_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (lose_lock) begin
                        state        <= HUNT;
                        align_locked <= 1'b0;
                        if (realign_count != '1) begin
                            realign_count <= realign_count + CNT_W'(1);
                        end
                    end else if (!sync_seen) begin
                        if (sync_status) sync_seen <= 1'b1;
                        else             tmo_cnt   <= tmo_cnt - TMO_W'(1);
                    end
                end
                default: begin
                    state        <= HUNT;
                    align_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Directed bench for comma_align_ctrl: /I2/ streams at several offsets,
// sync timeout and loss, offset conflict and asynchronous reset.
module tb_comma_align_ctrl;
    import comma_align_ctrl_pkg::*;

    localparam logic [9:0] KC    = K28_5_RDN;
    localparam logic [9:0] D16_2 = 10'b1001000101;

    logic       clk = 1'b0;
    logic       RESET;
    logic [9:0] rx_raw;
    logic       sync_status;
    logic [9:0] rx_code_group;
    logic [3:0] bit_offset;
    logic       align_locked;
    logic [7:0] realign_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0]  a_prev;
    int          idx;
    logic [19:0] rdp_win;

    typedef struct {
        logic [9:0] raw;
        logic [9:0] exp_cg;
        logic [3:0] exp_off;
        logic       exp_lock;
    } vec_t;
    vec_t vecs[12];

    comma_align_ctrl #(
        .CONFIRM_COMMAS (3),
        .SYNC_TIMEOUT   (64),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .RESET         (RESET),
        .rx_raw        (rx_raw),
        .sync_status   (sync_status),
        .rx_code_group (rx_code_group),
        .bit_offset    (bit_offset),
        .align_locked  (align_locked),
        .realign_count (realign_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input logic [9:0] raw, input logic s);
        rx_raw      = raw;
        sync_status = s;
        @(posedge clk);
        #1;
    endtask

    // Next /I2/ word, presented with the serial stream delayed by k bits.
    task automatic send(input int k, input logic s);
        logic [9:0]  cur;
        logic [19:0] pair;
        cur    = (idx % 2 == 0) ? KC : D16_2;
        pair   = {a_prev, cur} >> k;
        a_prev = cur;
        idx++;
        tick(pair[9:0], s);
    endtask

    task automatic do_reset();
        RESET       = 1'b0;
        rx_raw      = '0;
        sync_status = 1'b0;
        a_prev      = '0;
        idx         = 0;
        repeat (2) @(posedge clk);
        #2 RESET = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{KC,    10'h000, 4'd0, 1'b0};
        vecs[1]  = '{D16_2, 10'h000, 4'd0, 1'b0};
        vecs[2]  = '{KC,    KC,      4'd0, 1'b0};
        vecs[3]  = '{D16_2, D16_2,   4'd0, 1'b0};
        vecs[4]  = '{KC,    KC,      4'd0, 1'b0};
        vecs[5]  = '{D16_2, D16_2,   4'd0, 1'b0};
        vecs[6]  = '{KC,    KC,      4'd0, 1'b0};
        vecs[7]  = '{D16_2, D16_2,   4'd0, 1'b0};
        vecs[8]  = '{KC,    KC,      4'd0, 1'b1};
        vecs[9]  = '{D16_2, D16_2,   4'd0, 1'b1};
        vecs[10] = '{KC,    KC,      4'd0, 1'b1};
        vecs[11] = '{D16_2, D16_2,   4'd0, 1'b1};

        // Aligned idle, sync tied high
        do_reset();
        check("rst_cg",    32'(rx_code_group), 0);
        check("rst_off",   32'(bit_offset),    0);
        check("rst_lock",  32'(align_locked),  0);
        check("rst_count", 32'(realign_count), 0);
        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].raw, 1'b1);
            check($sformatf("idle%0d_cg", i),    32'(rx_code_group), 32'(vecs[i].exp_cg));
            check($sformatf("idle%0d_off", i),   32'(bit_offset),    32'(vecs[i].exp_off));
            check($sformatf("idle%0d_lock", i),  32'(align_locked),  32'(vecs[i].exp_lock));
            check($sformatf("idle%0d_count", i), 32'(realign_count), 0);
        end

        // Sync loss while the stream moves to offset 7
        a_prev = D16_2;
        idx    = 12;
        send(7, 1'b0);
        check("loss_lock",  32'(align_locked),  0);
        check("loss_count", 32'(realign_count), 1);
        for (int t = 13; t <= 20; t++) begin
            send(7, 1'b0);
            if (t == 13) check("loss_off_hold", 32'(bit_offset), 0);
            if (t == 14) check("loss_off_7", 32'(bit_offset), 7);
            if (t == 19) check("loss_prelock", 32'(align_locked), 0);
        end
        check("loss_relock", 32'(align_locked),  1);
        check("loss_off",    32'(bit_offset),    7);
        check("loss_cnt",    32'(realign_count), 1);
        check("loss_cg",     32'(rx_code_group), 32'(KC));

        // Stream rotated by 3 bits
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(3, 1'b1);
            if (i == 1)  check("shift_off_pre", 32'(bit_offset), 0);
            if (i == 2)  check("shift_off", 32'(bit_offset), 3);
            if (i == 7)  check("shift_prelock", 32'(align_locked), 0);
            if (i == 8)  check("shift_lock", 32'(align_locked), 1);
            if (i == 10) check("shift_cg_k", 32'(rx_code_group), 32'(KC));
            if (i == 11) check("shift_cg_d", 32'(rx_code_group), 32'(D16_2));
        end
        check("shift_off_end", 32'(bit_offset),    3);
        check("shift_count",   32'(realign_count), 0);

        // Comma at offset 5 while confirming offset 2
        do_reset();
        send(2, 1'b1);
        send(2, 1'b1);
        for (int i = 2; i <= 12; i++) begin
            send(5, 1'b1);
            if (i == 2) check("cfl_off_first", 32'(bit_offset), 2);
            if (i == 4) check("cfl_off_kept", 32'(bit_offset), 2);
            if (i == 6) check("cfl_off_new", 32'(bit_offset), 5);
            if (i < 12) check($sformatf("cfl%0d_nolock", i), 32'(align_locked), 0);
        end
        check("cfl_lock",  32'(align_locked), 1);
        check("cfl_off",   32'(bit_offset),   5);

        // Sync never rises: timeout then re-lock
        do_reset();
        for (int i = 0; i <= 80; i++) begin
            send(0, 1'b0);
            case (i)
                8:  check("tmo_lock", 32'(align_locked), 1);
                71: begin
                    check("tmo_still_lock", 32'(align_locked),  1);
                    check("tmo_count0",     32'(realign_count), 0);
                end
                72: begin
                    check("tmo_drop",   32'(align_locked),  0);
                    check("tmo_count1", 32'(realign_count), 1);
                end
                79: check("tmo_prerelock", 32'(align_locked), 0);
                80: begin
                    check("tmo_relock",  32'(align_locked),  1);
                    check("tmo_off",     32'(bit_offset),    0);
                    check("tmo_count_k", 32'(realign_count), 1);
                end
                default: ;
            endcase
        end

        // Asynchronous reset while locked, between clock edges
        #2 RESET = 1'b0;
        #1;
        check("arst_cg",    32'(rx_code_group), 0);
        check("arst_off",   32'(bit_offset),    0);
        check("arst_lock",  32'(align_locked),  0);
        check("arst_count", 32'(realign_count), 0);
        repeat (2) @(posedge clk);
        #2 RESET = 1'b1;
        check("post_count", 32'(realign_count), 0);
        check("post_lock",  32'(align_locked),  0);

        // Back in HUNT: a lone RD+ comma at offset 4 is picked up
        rdp_win = {4'b0000, K28_5_RDP, 6'b000000};
        tick(rdp_win[19:10], 1'b0);
        tick(rdp_win[9:0], 1'b0);
        check("rdp_off_pre", 32'(bit_offset), 0);
        tick(10'h000, 1'b0);
        check("rdp_off",   32'(bit_offset),    4);
        check("rdp_lock",  32'(align_locked),  0);
        check("rdp_count", 32'(realign_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comma_align_ctrl.md
# comma_align_ctrl

Receive-side word-alignment controller for the 1000BASE-X PCS. It sits between the deserializer and `sincronizador`. It searches the raw 10-bit stream for the comma at each of the 10 bit offsets and selects the bit offset. It then drives aligned `rx_code_group` words into the synchronizer and re-hunts whenever the synchronizer fails to gain sync or loses it.

## Interface
- `CONFIRM_COMMAS`, default 3: further commas required at the chosen offset before lock.
- `SYNC_TIMEOUT`, default 64: cycles in LOCKED allowed for `sync_status` to rise.
- `CNT_W`, default 8: width of `realign_count`.
- `clk`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `rx_raw`  in  10  unaligned deserializer word; bit 9 is the first bit received.
- `sync_status`  in  1  from `sincronizador`; 1 = synchronized.
- `rx_code_group`  out  10  aligned code group to `sincronizador`; reset 10'b0.
- `bit_offset`  out  4  selected offset, 0..9; reset 0.
- `align_locked`  out  1  high only in LOCKED; reset 0.
- `realign_count`  out  CNT_W  count of LOCKED→HUNT transitions; saturates at all-ones; reset 0.

## Operation
- **Pipeline:**
  - `r0 <= rx_raw`, `r1 <= r0`; window W = {r1, r0} (20 bits).
  - Candidate k = W[19-k : 10-k], for k = 0..9.
- **Comma hit vector:** `hit[k]` = 1 when candidate k bits [9:3] equal 7'b0011111 or 7'b1100000.
- **Output:** `rx_code_group <= candidate(bit_offset)` every cycle, in all states.
- **HUNT** (reset state; `align_locked` = 0):
  - If any `hit` is set: load `bit_offset` with the lowest k where hit[k] = 1, clear the confirm counter, go to CONFIRM.
  - Otherwise stay in HUNT.
- **CONFIRM:**
  - hit at `bit_offset` only: increment the confirm counter. When it reaches CONFIRM_COMMAS, go to LOCKED and clear the timeout counter.
  - hit at any other offset, whether or not hit at `bit_offset` is also set: return to HUNT. `bit_offset` is kept until the next hit.
  - No hit: hold.
- **LOCKED** (`align_locked` = 1):
  - `sync_status` = 0 and the synchronizer has not yet gone high since entry: increment the timeout counter. At SYNC_TIMEOUT, go to HUNT.
  - `sync_status` falls 1→0 after having been 1: go to HUNT next cycle.
  - Commas at other offsets are ignored; the synchronizer owns the error policy.
- **Every LOCKED→HUNT transition** increments `realign_count` (saturating).
- **Reset mid-operation:** all state and outputs return to reset values asynchronously, and the pipeline registers clear.

## Timing
- **Latency:** a word presented on `rx_raw` in cycle n with offset 0 appears on `rx_code_group` in cycle n+3. Offset k takes k bits from the later word.
- **Hit detection:** combinational on W; the state update and `bit_offset` load happen on the same edge as the output register. The first aligned word therefore appears on `rx_code_group` one cycle after the HUNT→CONFIRM edge.
- **`align_locked`:** rises on the edge where the CONFIRM_COMMAS-th confirming comma is registered and falls on the LOCKED→HUNT edge.
- **Timeout:** the LOCKED→HUNT transition occurs exactly SYNC_TIMEOUT cycles after LOCKED entry if `sync_status` stayed 0.
- **Simultaneous events:** a `sync_status` fall and the timeout expiring in the same cycle cause a single transition and a single increment.

## Structure
- **Shared PCS package:**
  - comma constants `COMMA_P` = 7'b0011111 and `COMMA_N` = 7'b1100000;
  - K28.5 constants 10'b0011111010 and 10'b1100000101;
  - the state encoding HUNT = 0, CONFIRM = 1, LOCKED = 2.
- **Sub-module `comma_detect`:** 20-bit window in, 10-bit `hit` vector out, purely combinational.
- The FSM, counters and output mux stay in `comma_align_ctrl`.

## Test plan
- **Aligned idle:** /I2/ stream (K28.5 RD- 10'b0011111010, then D16.2), offset 0, `sync_status` tied 1 → `bit_offset` = 0, `align_locked` rises after the 4th comma is seen, `rx_code_group` equals the input delayed 3 cycles.
- **Shifted stream:** same stream rotated 3 bits → `bit_offset` = 3, `rx_code_group` carries 10'b0011111010 on comma words, `realign_count` = 0.
- **Sync timeout:** lock, hold `sync_status` = 0 → HUNT exactly 64 cycles after lock, `realign_count` = 1, re-lock follows.
- **Sync loss:** lock, pulse `sync_status` 1 then 0, then shift the stream to offset 7 → HUNT the next cycle, then `bit_offset` = 7 and LOCKED, `realign_count` = 1.
- **Conflict in CONFIRM:** after the first comma at offset 2, inject a comma at offset 5 → return to HUNT, then CONFIRM at 5; `align_locked` never asserted at 2.
- **Reset mid-lock:** assert `RESET` = 0 in LOCKED → all outputs 0 immediately, without waiting for `clk`; after release the block is in HUNT with `realign_count` = 0.
